// File: rtl/alarm_ctrl_24hr.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ctrl_24hr
// Description : Alarm controller for a 24-hour clock with ringing auto-stop,
//               bounded snooze and validated alarm-time loading.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl_24hr #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic       alarm_en_i,
    input  logic       alarm_set_i,
    input  logic [4:0] alarm_hour_i,
    input  logic [5:0] alarm_min_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    output logic       alarm_o,
    output logic [1:0] state_o,
    output logic [4:0] alarm_hour_o,
    output logic [5:0] alarm_min_o,
    output logic [1:0] snooze_cnt_o
);

    localparam int c_RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int c_SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

    localparam logic [c_RING_W-1:0] c_RING_LAST   = c_RING_W'(RING_SEC - 1);
    localparam logic [c_SNZ_W-1:0]  c_SNZ_LAST    = c_SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]          c_SNOOZE_MAX  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [c_RING_W-1:0] ring_q,   ring_d;
    logic [c_SNZ_W-1:0]  snz_q,    snz_d;
    logic [1:0]          scnt_q,   scnt_d;
    logic [4:0]          ahour_q,  ahour_d;
    logic [5:0]          amin_q,   amin_d;
    logic                match_d_q;
    logic [5:0]          sec_prev_q;

    logic w_sec_tick;
    logic w_match;
    logic w_trigger;
    logic w_set_ok;

    assign w_sec_tick = (sec_i != sec_prev_q);
    assign w_match    = alarm_en_i && (hour_i == ahour_q) && (min_i == amin_q)
                        && (sec_i == 6'd0);
    // Edge-detect so a held match (or a time jump landing on it) fires once.
    assign w_trigger  = w_match && !match_d_q;
    assign w_set_ok   = alarm_set_i && (alarm_hour_i <= 5'd23) && (alarm_min_i <= 6'd59);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            ring_q     <= '0;
            snz_q      <= '0;
            scnt_q     <= '0;
            ahour_q    <= '0;
            amin_q     <= '0;
            match_d_q  <= 1'b1;
            sec_prev_q <= sec_i;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            scnt_q     <= scnt_d;
            ahour_q    <= ahour_d;
            amin_q     <= amin_d;
            match_d_q  <= w_match;
            sec_prev_q <= sec_i;
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        scnt_d  = scnt_q;
        ahour_d = ahour_q;
        amin_d  = amin_q;

        if (w_set_ok) begin
            ahour_d = alarm_hour_i;
            amin_d  = alarm_min_i;
            state_d = ST_IDLE;
            scnt_d  = '0;
        end else if (!alarm_en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_trigger) begin
                        state_d = ST_RINGING;
                        ring_d  = '0;
                        scnt_d  = '0;
                    end
                end
                ST_RINGING: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                    end else if (snooze_i && (scnt_q < c_SNOOZE_MAX)) begin
                        state_d = ST_SNOOZE;
                        scnt_d  = scnt_q + 2'd1;
                        snz_d   = '0;
                    end else if (w_sec_tick) begin
                        if (ring_q == c_RING_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            ring_d = ring_q + c_RING_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_i) begin
                        state_d = ST_IDLE;
                    end else if (w_sec_tick) begin
                        if (snz_q == c_SNZ_LAST) begin
                            state_d = ST_RINGING;
                            ring_d  = '0;
                        end else begin
                            snz_d = snz_q + c_SNZ_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign alarm_o      = (state_q == ST_RINGING);
    assign state_o      = state_q;
    assign alarm_hour_o = ahour_q;
    assign alarm_min_o  = amin_q;
    assign snooze_cnt_o = scnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl_24hr.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ctrl_24hr
// Description : Scoreboard bench for alarm_ctrl_24hr: directed scenarios plus
//               randomized stimulus against a time-of-day reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl_24hr;

    localparam int c_RING    = 60;
    localparam int c_SNZ     = 300;
    localparam int c_MAXS    = 3;
    localparam int c_IDLE    = 0;
    localparam int c_RINGING = 1;
    localparam int c_SNOOZE  = 2;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [4:0] hour_i;
    logic [5:0] min_i;
    logic [5:0] sec_i;
    logic       alarm_en_i;
    logic       alarm_set_i;
    logic [4:0] alarm_hour_i;
    logic [5:0] alarm_min_i;
    logic       snooze_i;
    logic       stop_i;
    logic       alarm_o;
    logic [1:0] state_o;
    logic [4:0] alarm_hour_o;
    logic [5:0] alarm_min_o;
    logic [1:0] snooze_cnt_o;

    always #5 clk = ~clk;

    alarm_ctrl_24hr #(
        .RING_SEC   (c_RING),
        .SNOOZE_SEC (c_SNZ),
        .MAX_SNOOZE (c_MAXS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .hour_i       (hour_i),
        .min_i        (min_i),
        .sec_i        (sec_i),
        .alarm_en_i   (alarm_en_i),
        .alarm_set_i  (alarm_set_i),
        .alarm_hour_i (alarm_hour_i),
        .alarm_min_i  (alarm_min_i),
        .snooze_i     (snooze_i),
        .stop_i       (stop_i),
        .alarm_o      (alarm_o),
        .state_o      (state_o),
        .alarm_hour_o (alarm_hour_o),
        .alarm_min_o  (alarm_min_o),
        .snooze_cnt_o (snooze_cnt_o)
    );

    typedef struct packed {
        logic       alarm;
        logic [1:0] state;
        logic [4:0] ahour;
        logic [5:0] amin;
        logic [1:0] scnt;
    } obs_t;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Stimulus intent: wall clock as seconds-of-day plus control requests.
    int tod;
    bit t_rst, t_en, t_set, t_snz, t_stop;
    int t_ah, t_am;

    // Reference model: alarm kept as minute-of-day, elapsed seconds counted up.
    int m_state, m_alarm, m_snoozes, m_rang, m_snoozed, m_prev_sec;
    bit m_prev_match;

    task automatic model_step(input int h, input int m, input int s);
        bit match, fresh, tick;
        if (t_rst) begin
            m_state = c_IDLE; m_alarm = 0; m_snoozes = 0;
            m_rang = 0; m_snoozed = 0; m_prev_match = 1; m_prev_sec = s;
            return;
        end
        match = t_en && (h * 60 + m == m_alarm) && (s == 0);
        fresh = match && !m_prev_match;
        tick  = (s != m_prev_sec);
        m_prev_match = match;
        m_prev_sec   = s;
        if (t_set && t_ah <= 23 && t_am <= 59) begin
            m_alarm = t_ah * 60 + t_am; m_state = c_IDLE; m_snoozes = 0;
        end else if (!t_en) begin
            m_state = c_IDLE;
        end else if (m_state == c_IDLE) begin
            if (fresh) begin m_state = c_RINGING; m_rang = 0; m_snoozes = 0; end
        end else if (m_state == c_RINGING) begin
            if (t_stop) m_state = c_IDLE;
            else if (t_snz && m_snoozes < c_MAXS) begin
                m_state = c_SNOOZE; m_snoozes++; m_snoozed = 0;
            end else if (tick) begin
                m_rang++;
                if (m_rang >= c_RING) m_state = c_IDLE;
            end
        end else begin
            if (t_stop) m_state = c_IDLE;
            else if (tick) begin
                m_snoozed++;
                if (m_snoozed >= c_SNZ) begin m_state = c_RINGING; m_rang = 0; end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.alarm = (m_state == c_RINGING);
        o.state = 2'(m_state);
        o.ahour = 5'(m_alarm / 60);
        o.amin  = 6'(m_alarm % 60);
        o.scnt  = 2'(m_snoozes);
        return o;
    endfunction

    // One clock of stimulus; its expected post-edge outputs go to the scoreboard.
    task automatic step();
        int h, m, s;
        @(negedge clk);
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        reset_i      = t_rst;
        hour_i       = 5'(h);
        min_i        = 6'(m);
        sec_i        = 6'(s);
        alarm_en_i   = t_en;
        alarm_set_i  = t_set;
        alarm_hour_i = 5'(t_ah);
        alarm_min_i  = 6'(t_am);
        snooze_i     = t_snz;
        stop_i       = t_stop;
        model_step(h, m, s);
        sb.push_back(model_obs());
    endtask

    task automatic next_sec();
        tod = (tod + 1) % 86400;
        step();
    endtask

    task automatic run_secs(input int n);
        for (int i = 0; i < n; i++) begin
            next_sec();
            step();
        end
    endtask

    task automatic do_trigger();
        tod = 7 * 3600 + 29 * 60 + 59;
        step();
        step();
        next_sec();
    endtask

    task automatic pulse_snooze();
        t_snz = 1; step(); t_snz = 0;
    endtask

    // Observe the edge that applies the step just issued.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_eq(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    initial begin : monitor
        obs_t exp_o, got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_o     = sb.pop_front();
                got.alarm = alarm_o;
                got.state = state_o;
                got.ahour = alarm_hour_o;
                got.amin  = alarm_min_o;
                got.scnt  = snooze_cnt_o;
                vectors++;
                if (got !== exp_o) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: alarm/state/hour/min/snz got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                             $time, got.alarm, got.state, got.ahour, got.amin, got.scnt,
                             exp_o.alarm, exp_o.state, exp_o.ahour, exp_o.amin, exp_o.scnt);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        reset_i = 1; hour_i = 0; min_i = 0; sec_i = 0; alarm_en_i = 0;
        alarm_set_i = 0; alarm_hour_i = 0; alarm_min_i = 0; snooze_i = 0; stop_i = 0;
        tod = 7 * 3600; t_rst = 1; t_en = 0; t_set = 0; t_snz = 0; t_stop = 0;
        t_ah = 0; t_am = 0;

        step(); step(); sync();
        expect_eq("reset_state", state_o, 0);
        expect_eq("reset_alarm", alarm_o, 0);
        expect_eq("reset_hour", alarm_hour_o, 0);
        expect_eq("reset_min", alarm_min_o, 0);
        expect_eq("reset_snz", snooze_cnt_o, 0);
        t_rst = 0;

        // Load 07:30 and ring on the 07:29:59 -> 07:30:00 rollover.
        t_set = 1; t_ah = 7; t_am = 30; step(); t_set = 0; sync();
        expect_eq("set_hour", alarm_hour_o, 7);
        expect_eq("set_min", alarm_min_o, 30);
        t_en = 1;
        tod = 7 * 3600 + 29 * 60 + 58; step(); step();
        next_sec(); sync();
        expect_eq("pre_match_alarm", alarm_o, 0);
        next_sec(); sync();
        expect_eq("trigger_alarm", alarm_o, 1);
        expect_eq("trigger_state", state_o, 1);

        // Auto-stop after 60 ticks.
        step();
        run_secs(59); sync();
        expect_eq("ring59_state", state_o, 1);
        next_sec(); sync();
        expect_eq("ring60_alarm", alarm_o, 0);
        expect_eq("ring60_state", state_o, 0);

        // Snooze expiry returns to ringing after 300 ticks.
        do_trigger();
        pulse_snooze(); sync();
        expect_eq("snooze1_state", state_o, 2);
        expect_eq("snooze1_cnt", snooze_cnt_o, 1);
        run_secs(299); sync();
        expect_eq("snooze299_state", state_o, 2);
        next_sec(); sync();
        expect_eq("snooze300_state", state_o, 1);
        expect_eq("snooze300_alarm", alarm_o, 1);

        // Snooze limit, then stop.
        pulse_snooze(); run_secs(300);
        pulse_snooze(); run_secs(300);
        pulse_snooze(); sync();
        expect_eq("snooze4_state", state_o, 1);
        expect_eq("snooze4_cnt", snooze_cnt_o, 3);
        t_stop = 1; step(); t_stop = 0; sync();
        expect_eq("stop_state", state_o, 0);

        // Stop beats snooze in the same cycle.
        do_trigger();
        pulse_snooze(); run_secs(300);
        t_snz = 1; t_stop = 1; step(); t_snz = 0; t_stop = 0; sync();
        expect_eq("stop_snz_state", state_o, 0);
        expect_eq("stop_snz_cnt", snooze_cnt_o, 1);

        // No retrigger while the match persists.
        do_trigger();
        t_stop = 1; step(); t_stop = 0; step(); step(); sync();
        expect_eq("no_retrigger", state_o, 0);

        // Disabling the alarm forces idle but keeps the snooze count.
        do_trigger();
        pulse_snooze();
        t_en = 0; step(); sync();
        expect_eq("disable_state", state_o, 0);
        expect_eq("disable_cnt", snooze_cnt_o, 1);
        t_en = 1; step();

        // Reset while snoozing.
        do_trigger();
        pulse_snooze();
        t_rst = 1; step(); t_rst = 0; sync();
        expect_eq("rst_snz_state", state_o, 0);
        expect_eq("rst_snz_alarm", alarm_o, 0);
        expect_eq("rst_snz_hour", alarm_hour_o, 0);
        expect_eq("rst_snz_min", alarm_min_o, 0);
        expect_eq("rst_snz_cnt", snooze_cnt_o, 0);

        // Out-of-range load ignored; valid load during ringing forces idle.
        t_set = 1; t_ah = 7; t_am = 30; step(); t_set = 0;
        do_trigger();
        t_set = 1; t_ah = 24; t_am = 10; step(); t_set = 0; sync();
        expect_eq("bad_set_hour", alarm_hour_o, 7);
        expect_eq("bad_set_min", alarm_min_o, 30);
        expect_eq("bad_set_state", state_o, 1);
        t_set = 1; t_ah = 23; t_am = 59; step(); t_set = 0; sync();
        expect_eq("good_set_hour", alarm_hour_o, 23);
        expect_eq("good_set_min", alarm_min_o, 59);
        expect_eq("good_set_state", state_o, 0);

        // Randomized traffic concentrated around the stored alarm time.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55)      tod = (tod + 1) % 86400;
            else if (r < 62) tod = (m_alarm * 60 - int'($urandom_range(0, 2)) + 86400) % 86400;
            else if (r < 64) tod = int'($urandom_range(0, 86399));
            t_snz  = ($urandom_range(0, 9) == 0);
            t_stop = ($urandom_range(0, 19) == 0);
            t_set  = ($urandom_range(0, 39) == 0);
            t_ah   = int'($urandom_range(0, 31));
            t_am   = int'($urandom_range(0, 63));
            t_rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) t_en = !t_en;
            step();
        end
        t_snz = 0; t_stop = 0; t_set = 0; t_rst = 0;

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_ctrl_24hr.md
ALARM_CTRL_24HR -- requirements
Module: alarm_ctrl_24hr

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, meaning seconds of ringing before auto-stop.
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, meaning snooze length in seconds.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, meaning snoozes allowed per alarm event.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port hour_i, input, 5, meaning current hour 0-23 from the 24-hour ms clock (hour_o).
REQ-007 SHALL have port min_i, input, 6, meaning current minute 0-59 (min_o).
REQ-008 SHALL have port sec_i, input, 6, meaning current second 0-59 (sec_o).
REQ-009 SHALL have port alarm_en_i, input, 1, meaning alarm armed when high.
REQ-010 SHALL have port alarm_set_i, input, 1, meaning load request for alarm time.
REQ-011 SHALL have ports alarm_hour_i (5) and alarm_min_i (6), inputs, meaning alarm time to load.
REQ-012 SHALL have ports snooze_i and stop_i, inputs, 1 each, meaning user snooze and stop, level-sampled per clock.
REQ-013 SHALL have port alarm_o, output, 1, meaning buzzer drive, high only in RINGING.
REQ-014 SHALL have port state_o, output, 2, meaning FSM state: 0 IDLE, 1 RINGING, 2 SNOOZE; 3 unused.
REQ-015 SHALL have ports alarm_hour_o (5) and alarm_min_o (6), outputs, meaning stored alarm time.
REQ-016 SHALL have port snooze_cnt_o, output, 2, meaning snoozes used in current alarm event.

Function
REQ-017 SHALL generate sec_tick for one cycle whenever sec_i differs from its registered copy sec_prev.
REQ-018 SHALL define match = alarm_en_i and hour_i==alarm_hour_o and min_i==alarm_min_o and sec_i==0; trigger = match and not match_d (match_d = match registered).
REQ-019 SHALL on alarm_set_i load alarm_hour_i/alarm_min_i only if hour<=23 and min<=59; out-of-range request ignored entirely; valid load forces IDLE, clears snooze_cnt_o.
REQ-020 SHALL in IDLE move to RINGING on trigger, clearing ring counter and snooze_cnt_o; alarm_o high on the clock after match first seen.
REQ-021 SHALL in RINGING: stop_i -> IDLE; else snooze_i with snooze_cnt_o<MAX_SNOOZE -> SNOOZE, snooze_cnt_o+1, snooze timer cleared; else on sec_tick, ring counter ==RING_SEC-1 -> IDLE, otherwise ring counter+1.
REQ-022 SHALL ignore snooze_i in RINGING once snooze_cnt_o==MAX_SNOOZE (stay RINGING).
REQ-023 SHALL in SNOOZE: stop_i -> IDLE; else on sec_tick, snooze timer ==SNOOZE_SEC-1 -> RINGING with ring counter cleared, otherwise timer+1.
REQ-024 SHALL force IDLE from any state when alarm_en_i is low; snooze_cnt_o retained until next trigger.
REQ-025 SHALL apply priority per cycle: reset_i > valid alarm_set_i > alarm_en_i low > stop_i > snooze_i > sec_tick.
REQ-026 SHALL not retrigger while match stays high; a clock Timeset jump into a matching time with sec 0 SHALL trigger like a normal rollover.
REQ-027 SHALL size counters to hold RING_SEC-1 and SNOOZE_SEC-1 without wrap; state 3 SHALL recover to IDLE next clock.

Reset
REQ-028 SHALL on reset_i set state IDLE, alarm_o 0, alarm_hour_o 0, alarm_min_o 0, snooze_cnt_o 0, counters 0, match_d 1 (no trigger on first post-reset cycle), sec_prev <= sec_i.
REQ-029 SHALL let reset_i mid-RINGING or mid-SNOOZE drop alarm_o the next clock and discard all timing.

Verification
REQ-030 Set 07:30, enable, drive time 07:29:59 -> 07:30:00 -> alarm_o 1 one clock later, state_o 1.
REQ-031 Ringing, hold sec ticks for 60 seconds with no input -> alarm_o 0 after 60th tick, state_o 0.
REQ-032 Ringing, pulse snooze_i -> state_o 2, snooze_cnt_o 1; 300 sec ticks later -> state_o 1, alarm_o 1.
REQ-033 Snooze three times, fourth snooze_i during RINGING -> stays RINGING, snooze_cnt_o 3; stop_i -> IDLE.
REQ-034 alarm_set_i with hour 24 min 10 -> stored 07:30 unchanged; with 23:59 -> alarm_hour_o 23, alarm_min_o 59, state IDLE.
REQ-035 stop_i and snooze_i same cycle in RINGING -> IDLE, snooze_cnt_o unchanged; reset_i in SNOOZE -> all outputs reset values next clock.
